// File: rtl/sc_bit_accumulator.sv
// sc_bit_accumulator: counts 1-bits on NLANE stochastic lanes over 2^IWID beats.
// Optional macro SC_ACC_BIPOLAR_EN selects a two's-complement bipolar result.
module sc_bit_accumulator #(
    parameter int IWID = 4,
    parameter int NLANE = 1,
    localparam int OWID = IWID + $clog2(NLANE) + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iStart,
    input  logic             iEn,
    input  logic [NLANE-1:0] iDbit,
    output logic             oBusy,
    output logic             oValid,
    input  logic             iReady,
    output logic [OWID-1:0]  oData
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t            state;
    state_t            stateNxt;
    logic [OWID-1:0]   acc;
    logic [OWID-1:0]   accNxt;
    logic [IWID-1:0]   cnt;
    logic [IWID-1:0]   cntNxt;
    logic [OWID-1:0]   dataNxt;
    logic [OWID-1:0]   pop;
    logic [OWID-1:0]   accSum;
    logic [OWID-1:0]   result;
    logic              cntLast;

    // Per-cycle popcount across all lanes
    always_comb begin
        pop = '0;
        for (int i = 0; i < NLANE; i++) begin
            pop = pop + OWID'(iDbit[i]);
        end
    end

    assign accSum  = acc + pop;
    assign cntLast = (cnt == '1);

`ifdef SC_ACC_BIPOLAR_EN
    localparam logic [OWID-1:0] FULL = OWID'(NLANE) << IWID;

    // Bipolar value 2*acc - full-scale; wraps into two's complement
    assign result = (accSum << 1) - FULL;
`else
    assign result = accSum;
`endif

    // State, accumulator, beat counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            oData <= '0;
        end else begin
            state <= stateNxt;
            acc   <= accNxt;
            cnt   <= cntNxt;
            oData <= dataNxt;
        end
    end

    // Next-state logic: window start, beat accumulation, handoff
    always_comb begin
        stateNxt = state;
        accNxt   = acc;
        cntNxt   = cnt;
        dataNxt  = oData;
        unique case (state)
            IDLE: begin
                if (iStart) begin
                    accNxt   = '0;
                    cntNxt   = '0;
                    stateNxt = RUN;
                end
            end
            RUN: begin
                if (iEn) begin
                    accNxt = accSum;
                    cntNxt = cnt + 1'b1;
                    if (cntLast) begin
                        dataNxt  = result;
                        stateNxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (iReady) begin
                    if (iStart) begin
                        accNxt   = '0;
                        cntNxt   = '0;
                        stateNxt = RUN;
                    end else begin
                        stateNxt = IDLE;
                    end
                end
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    assign oBusy  = (state == RUN);
    assign oValid = (state == HOLD);

endmodule

// File: doc/sc_bit_accumulator.md
# sc_bit_accumulator

Downstream consumer of the stochastic multiplier's output bitstream: it counts the 1-bits on one or more parallel stochastic lanes over a fixed window of 2^IWID valid cycles and converts the stream back to a binary value. It sits between the `Mul` array and the binary back-end (activation and requantisation), and hands each result off with a valid/ready handshake. One accumulation window runs at a time. Back-to-back windows are supported with no idle cycle.

## Interface
- `IWID`, 4: RNG width of the upstream multiplier; window length is 2^IWID valid cycles.
- `NLANE`, 1: number of parallel bitstream lanes summed per cycle (≥1).
- `OWID`, localparam = IWID + $clog2(NLANE) + 2: result width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `iStart`  in  1  begin a new window; sampled in IDLE, or in HOLD together with the handshake.
- `iEn`  in  1  qualifies `iDbit` this cycle.
- `iDbit`  in  NLANE  stochastic bits, one per lane, from `Mul.oDbit`.
- `oBusy`  out  1  high in RUN.
- `oValid`  out  1  result available (HOLD state).
- `iReady`  in  1  consumer accepts `oData` when `oValid & iReady`.
- `oData`  out  OWID  accumulated result; stable while `oValid` is high.

## Operation
- FSM states: IDLE, RUN, HOLD. Encoding is free.
- **IDLE**
  - `iStart` = 1: clear the accumulator `acc` and the cycle counter `cnt` (IWID bits), then go to RUN.
  - Otherwise stay in IDLE.
- **RUN**
  - Each cycle with `iEn` = 1: `acc += popcount(iDbit)` and `cnt += 1`.
  - Cycles with `iEn` = 0 change nothing.
  - The accepted beat with `cnt == 2^IWID−1` is the last one. On that edge: register `oData` from the final sum (including that beat), go to HOLD, and wrap `cnt` to 0.
  - `iStart` is ignored in RUN.
- **HOLD**
  - `oValid` = 1 and `oData` is held.
  - `oValid & iReady` with `iStart` = 0: go to IDLE.
  - `oValid & iReady` with `iStart` = 1: clear `acc` and `cnt`, then go directly to RUN (back-to-back).
  - `iEn`/`iDbit` are ignored in HOLD and IDLE.
- **Arithmetic**
  - `acc` is unsigned, OWID bits. Its maximum is NLANE·2^IWID, which always fits, so there is no saturation or overflow logic.
  - Unipolar result = `acc`, zero-extended.
- **Reset** (any state, including mid-window): next state IDLE. `acc`, `cnt`, `oData`, `oValid` and `oBusy` all become 0. A partial window is discarded.

## Timing
- Reset values: `oValid` = 0, `oBusy` = 0, `oData` = 0.
- `oBusy` rises the cycle after `iStart` is sampled. It falls on the same edge that raises `oValid`.
- Latency: `oValid` rises on the edge that samples the 2^IWID-th accepted beat, i.e. 1 cycle after that beat is presented. With `iEn` held high, `oValid` is high 2^IWID+1 cycles after `iStart` is presented.
- `oValid` stays high until it is accepted. `oData` must not change while `oValid` = 1.
- `oValid` falls on the edge after `oValid & iReady`.
- Back-to-back: if `iStart` arrives with the accepting handshake, the first beat is accepted on the next cycle.
- Throughput with `iEn` held high: one result per 2^IWID+1 cycles.

## Configuration
- Macro: `SC_ACC_BIPOLAR_EN`.
- Defined: `oData` is two's-complement bipolar, equal to 2·`acc` − NLANE·2^IWID. The range is ±NLANE·2^IWID, which fits OWID signed bits. The conversion is registered into `oData` on the same edge as the unipolar case, so latency is unchanged.
- Undefined: `oData` is the unipolar count, and the subtractor is not synthesised.

## Test plan
- **Unipolar, all ones** (IWID=4, NLANE=1): `iStart` pulse, then `iEn`=1 and `iDbit`=1 for 16 cycles. Required: `oValid` 1 cycle after the last beat, `oData`=16, `oBusy` low from that edge.
- **Multiplier stream**: drive `iDbit` from a `Mul` with weight 10 (`iWeig`=10), data bit 1 and a free-running counter RNG for 16 cycles. Required: `oData`=10.
- **`iEn` gaps and backpressure**: insert 5 `iEn`=0 cycles mid-window; hold `iReady`=0 for 7 cycles after `oValid`. Required: result unchanged by the gaps, `oValid` and `oData` stable throughout, `oValid` drops 1 cycle after `iReady`=1.
- **Back-to-back, multi-lane** (NLANE=3): assert `iStart` together with the accepting handshake. Required: no IDLE cycle between windows. All-ones window gives `oData`=48; the following all-zeros window gives 0.
- **Reset mid-window**: assert `rst` after 9 beats, then start a fresh window of 16 ones. Required: outputs 0 during reset, and the new result is 16 with no carry-over from the discarded 9 beats.
- **Bipolar build** (`SC_ACC_BIPOLAR_EN`, NLANE=1): all-ones window gives `oData`=+16; all-zeros gives −16; alternating 1/0 gives 0.
